dly_line_cal_ctrl: RTL

//  Calibration/tracking controller for a digitally tuned delay line built from inverter

---
 rtl/dly_line_cal_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/dly_line_cal_ctrl.sv
// Delay-line tap calibration: sweeps the tap upward until the phase detector vote says
// "not early", then locks; optionally nudges the tap by +/-1 per window to follow drift.
module dly_line_cal_ctrl #(
  parameter int TAP_W  = 5,
  parameter int SETTLE = 4,
  parameter int AVG_W  = 3
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             START,
  input  logic             TRACK_EN,
  input  logic             PD_EARLY,
  output logic [TAP_W-1:0] TAP,
  output logic             TAP_UPD,
  output logic             BUSY,
  output logic             LOCKED,
  output logic             ERR
);

  localparam int N    = 2**AVG_W;
  localparam int CMAX = (SETTLE > N) ? SETTLE : N;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [TAP_W-1:0] TMAX = '1;
  localparam logic [AVG_W:0]   HALF = (AVG_W+1)'(N/2);

  typedef enum logic [3:0] {
    S_IDLE, S_SETTLE, S_SAMPLE, S_DECIDE, S_LOCK,
    S_TSETTLE, S_TSAMPLE, S_TDECIDE, S_FAIL
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [AVG_W:0]  r_ones;

  logic w_early, w_late, w_sweep, w_trk, w_restart;

  assign w_early   = r_ones > HALF;
  assign w_late    = r_ones < HALF;
  assign w_sweep   = (r_state == S_SETTLE) || (r_state == S_SAMPLE) || (r_state == S_DECIDE);
  assign w_trk     = (r_state == S_TSETTLE) || (r_state == S_TSAMPLE) || (r_state == S_TDECIDE);
  assign w_restart = START && !w_sweep;

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ones  <= '0;
      TAP     <= '0;
      TAP_UPD <= 1'b0;
      BUSY    <= 1'b0;
      LOCKED  <= 1'b0;
      ERR     <= 1'b0;
    end else begin
      TAP_UPD <= 1'b0;
      if (w_restart) begin
        r_state <= S_SETTLE;
        r_cnt   <= '0;
        r_ones  <= '0;
        TAP     <= '0;
        TAP_UPD <= (TAP != '0);
        BUSY    <= 1'b1;
        LOCKED  <= 1'b0;
        ERR     <= 1'b0;
      end else if (w_trk && !TRACK_EN) begin
        // partial tracking window is thrown away; tap stays where it is
        r_state <= S_LOCK;
        r_cnt   <= '0;
        r_ones  <= '0;
      end else begin
        case (r_state)
          S_SETTLE, S_TSETTLE: begin
            if (r_cnt == CW'(SETTLE-1)) begin
              r_cnt   <= '0;
              r_state <= (r_state == S_SETTLE) ? S_SAMPLE : S_TSAMPLE;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          S_SAMPLE, S_TSAMPLE: begin
            r_ones <= r_ones + {{AVG_W{1'b0}}, PD_EARLY};
            if (r_cnt == CW'(N-1)) begin
              r_cnt   <= '0;
              r_state <= (r_state == S_SAMPLE) ? S_DECIDE : S_TDECIDE;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          S_DECIDE: begin
            r_ones <= '0;
            if (w_early && TAP != TMAX) begin
              TAP     <= TAP + TAP_W'(1);
              TAP_UPD <= 1'b1;
              r_state <= S_SETTLE;
            end else if (w_early) begin
              ERR     <= 1'b1;
              BUSY    <= 1'b0;
              r_state <= S_FAIL;
            end else begin
              LOCKED  <= 1'b1;
              BUSY    <= 1'b0;
              r_state <= S_LOCK;
            end
          end
          S_TDECIDE: begin
            r_ones  <= '0;
            r_state <= S_TSETTLE;
            if (w_early && TAP != TMAX) begin
              TAP     <= TAP + TAP_W'(1);
              TAP_UPD <= 1'b1;
            end else if (w_late && TAP != '0) begin
              TAP     <= TAP - TAP_W'(1);
              TAP_UPD <= 1'b1;
            end
          end
          S_LOCK: begin
            if (TRACK_EN) begin
              r_state <= S_TSETTLE;
              r_cnt   <= '0;
              r_ones  <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
